bin_to_bcd_seq: RTL

//  Sequential double-dabble converter: BIN_W-bit unsigned binary -> DIGITS packed BCD digits.

---
 rtl/bin_to_bcd_pkg.sv | 14 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_pkg.sv
// rtl/bin_to_bcd_pkg.sv - shared constants and FSM state encoding for bin_to_bcd_seq
package bin_to_bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] MAX_DIGIT   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 to any digit of 5 or more
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] corrected
);

  assign corrected = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// Optional leading-zero flags on blank_o when BIN2BCD_BLANK_EN is defined.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [BIN_W-1:0]              bin_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                          ovf_o
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             blank_o
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{MAX_DIGIT}};

  state_t            state, state_next;
  logic              load_en, shift_en, done_en;
  logic [BIN_W-1:0]  shift_q;
  logic [BCD_W-1:0]  bcd_q, bcd_adj, result;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt_q;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_add3 u_add3 (
      .digit     (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    done_en    = 1'b0;
    ready_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          load_en    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_en    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A one leaving the top digit means the value needs more than DIGITS digits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (load_en) begin
      shift_q <= bin_i;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= CNT_W'(BIN_W);
    end else if (shift_en) begin
      bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[BIN_W-1]};
      shift_q <= shift_q << 1;
      ovf_q   <= ovf_q | bcd_adj[BCD_W-1];
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  assign result = ovf_q ? ALL_NINES : bcd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      bcd_o   <= '0;
      ovf_o   <= 1'b0;
    end else begin
      valid_o <= done_en;
      if (done_en) begin
        bcd_o <= result;
        ovf_o <= ovf_q;
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  logic [DIGITS-1:0] blank_next;
  logic              zero_above;

  // Walk down from the top digit; a digit is blank while everything above it is zero.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (result[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_next[k] = zero_above;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        blank_o <= BLANK_RST;
    else if (done_en) blank_o <= blank_next;
  end
`endif

endmodule
